// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit:
// funct3 codes, FSM states and small decode helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, funct3, op_a, op_b,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, kill, funct3, op_a, op_b,
    output ready, busy, done, result
  );
endinterface

// File: rtl/muldiv_neg.sv
// Conditional two's-complement negate; inc adds the carry-in so a high
// half can be negated correctly when the low half below it is nonzero.
module muldiv_neg #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic         inc,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = en ? (~a + {{(W-1){1'b0}}, inc}) : a;
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: radix-2 shift-add multiply and
// restoring divide sharing one 2*XLEN accumulator, one bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  state_t            state_reg;
  logic [2:0]        f3_reg;
  logic              sa_reg, sb_reg;
  logic [XLEN-1:0]   a_reg, b_reg, result_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [CW-1:0]     cnt_reg;
  logic              ready_reg, busy_reg, done_reg;

  logic            sa, sb, accept, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign sa       = is_signed_a(bus.funct3) & bus.op_a[XLEN-1];
  assign sb       = is_signed_b(bus.funct3) & bus.op_b[XLEN-1];
  assign accept   = bus.start & ready_reg & ~bus.kill;
  assign div_zero = is_div(bus.funct3) && (bus.op_b == '0);
  assign div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                    (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
  // funct3[1] selects the remainder flavour of a divide
  assign special_res = div_zero ? (bus.funct3[1] ? bus.op_a : '1)
                                : (bus.funct3[1] ? '0 : bus.op_a);

  muldiv_neg #(.W(XLEN)) u_neg_a (.en(sa), .inc(1'b1), .a(bus.op_a), .y(mag_a));
  muldiv_neg #(.W(XLEN)) u_neg_b (.en(sb), .inc(1'b1), .a(bus.op_b), .y(mag_b));

  logic [2*XLEN-1:0] acc_mul, acc_div, acc_next;
  logic [XLEN:0]     rem_shift, rem_diff;

  // counter doubles as the MSB-first bit index into the latched operand
  always_comb begin
    acc_mul   = {acc_reg[2*XLEN-2:0], 1'b0} +
                (b_reg[cnt_reg] ? {{XLEN{1'b0}}, a_reg} : {(2*XLEN){1'b0}});
    rem_shift = {acc_reg[2*XLEN-1:XLEN], a_reg[cnt_reg]};
    rem_diff  = rem_shift - {1'b0, b_reg};
    acc_div   = rem_diff[XLEN] ? {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                               : {rem_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};
    acc_next  = is_div(f3_reg) ? acc_div : acc_mul;
  end

  logic [XLEN-1:0] raw_res, fix_res;
  logic            neg_res, inc_res;

  always_comb begin
    raw_res = acc_next[XLEN-1:0];
    inc_res = 1'b1;
    neg_res = sa_reg ^ sb_reg;
    case (f3_reg)
      F3_MULH, F3_MULHSU, F3_MULHU: begin
        raw_res = acc_next[2*XLEN-1:XLEN];
        inc_res = (acc_next[XLEN-1:0] == '0);
      end
      F3_REM, F3_REMU: begin
        raw_res = acc_next[2*XLEN-1:XLEN];
        neg_res = sa_reg;
      end
      default: ;
    endcase
  end

  muldiv_neg #(.W(XLEN)) u_neg_res (.en(neg_res), .inc(inc_res), .a(raw_res), .y(fix_res));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      f3_reg     <= '0;
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      ready_reg  <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_CALC: begin
          if (bus.kill) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            acc_reg <= acc_next;
            if (cnt_reg == '0) begin
              state_reg  <= ST_DONE;
              result_reg <= fix_res;
              ready_reg  <= 1'b1;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        default: begin
          if (accept) begin
            f3_reg  <= bus.funct3;
            sa_reg  <= sa;
            sb_reg  <= sb;
            a_reg   <= mag_a;
            b_reg   <= mag_b;
            acc_reg <= '0;
            cnt_reg <= CW'(XLEN - 1);
            if (div_zero || div_ovf) begin
              state_reg  <= ST_DONE;
              result_reg <= special_res;
              ready_reg  <= 1'b1;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
            end else begin
              state_reg <= ST_CALC;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end
          end else begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.ready  = ready_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, control
// sequences (kill, ignored start, async reset, back-to-back) and random ops.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each operation
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = 64'($signed(sa) / $signed(sb));
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = 64'($signed(sa) % $signed(sb));
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bsy);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    bsy = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bsy++;
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    $display("op f3=%0d a=%h b=%h result=%h latency=%0d busy=%0d", f3, a, b, res, lat, bsy);
  endtask

  initial begin
    logic [31:0] res, exp;
    int          lat, bsy, hold_bad, seen_done;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        special;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 32};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 32};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 32};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33, 32};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33, 32};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1,  0};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0};
    vecs[12] = '{3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1,  0};
    vecs[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         1,  0};

    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready",  {31'd0, bus.ready}, 32'd1);
    check("reset_busy",   {31'd0, bus.busy},  32'd0);
    check("reset_done",   {31'd0, bus.done},  32'd0);
    check("reset_result", bus.result,         32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, bsy);
      check($sformatf("vec%0d_result", i), res,      vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i),    32'(bsy), 32'(vecs[i].bsy));
    end

    // kill in CALC cycle 10: no done, ready next cycle, result kept
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, bsy);
    check("kill_pre_result", res, 32'hFFFF_FFEB);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd3; bus.op_a = 32'h1234_5678; bus.op_b = 32'h9ABC_DEF1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("kill_busy_c10", {31'd0, bus.busy}, 32'd1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_ready", {31'd0, bus.ready}, 32'd1);
    check("kill_busy",  {31'd0, bus.busy},  32'd0);
    seen_done = 0;
    repeat (40) begin
      if (bus.done) seen_done++;
      @(negedge clk);
    end
    check("kill_no_done", 32'(seen_done), 32'd0);
    check("kill_result",  bus.result,     32'hFFFF_FFEB);
    $display("kill sequence result=%h", bus.result);

    // kill in IDLE blocks a special-case accept
    bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd5; bus.op_b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    check("idle_kill_done",   {31'd0, bus.done}, 32'd0);
    check("idle_kill_result", bus.result,        32'hFFFF_FFEB);
    $display("idle kill done=%0d", bus.done);

    // start during CALC is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      bus.start = (lat >= 3 && lat <= 7);
      if (bus.start) begin
        bus.funct3 = 3'($urandom_range(0, 7));
        bus.op_a   = $urandom();
        bus.op_b   = $urandom();
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("ignore_result",  bus.result, 32'd14);
    check("ignore_latency", 32'(lat),   32'd33);
    $display("ignored start result=%h latency=%0d", bus.result, lat);

    // asynchronous reset mid-CALC
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready",  {31'd0, bus.ready}, 32'd1);
    check("arst_busy",   {31'd0, bus.busy},  32'd0);
    check("arst_done",   {31'd0, bus.done},  32'd0);
    check("arst_result", bus.result,         32'd0);
    $display("async reset result=%h ready=%0d", bus.result, bus.ready);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back: start held in op 1's DONE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd7; bus.op_b = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_op1_latency", 32'(lat),   32'd33);
    check("b2b_op1_result",  bus.result, 32'hFFFF_FFEB);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    hold_bad = 0;
    while (!bus.done && lat < 200) begin
      if (bus.result !== 32'hFFFF_FFEB) hold_bad++;
      @(negedge clk);
      lat++;
    end
    check("b2b_op2_latency", 32'(lat),      32'd33);
    check("b2b_op2_result",  bus.result,    32'd14);
    check("b2b_hold",        32'(hold_bad), 32'd0);
    $display("back-to-back op2 result=%h latency=%0d", bus.result, lat);

    // randomized operations against the reference model
    for (int i = 0; i < 100; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      exp = model(f3, a, b);
      special = (f3[2] && b == 32'd0) ||
                ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      do_op(f3, a, b, res, lat, bsy);
      check($sformatf("rand%0d_result", i),  res,      exp);
      check($sformatf("rand%0d_latency", i), 32'(lat), special ? 32'd1 : 32'd33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RISC-V M-extension execution unit that takes the MUL/DIV/REM operations out of the single-cycle ALU path. It sits beside the ALU in the execute stage. The core pipeline stalls on `busy` when ALU control decodes an R-type with funct7[0]=1. The unit is parametrised in data width, covers all eight M-extension operations (signed/unsigned high-half multiply, unsigned divide/remainder), and implements RISC-V divide-by-zero and overflow results.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 4 and even.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request; sampled when `ready`=1.
- `kill` input 1: abort in-flight operation (pipeline flush).
- `funct3` input 3: M-extension op code.
- `op_a` input XLEN: rs1 value; sampled with `start`.
- `op_b` input XLEN: rs2 value; sampled with `start`.
- `ready` output 1: can accept `start` this cycle.
- `busy` output 1: operation in progress; stall request.
- `done` output 1: one-cycle pulse; `result` valid.
- `result` output XLEN: result; holds until the next `done`.

## Operation
- funct3 decode:
  - 000 MUL: low product.
  - 001 MULH: s×s high.
  - 010 MULHSU: s×u high.
  - 011 MULHU: u×u high.
  - 100 DIV.
  - 101 DIVU.
  - 110 REM.
  - 111 REMU.
- States are IDLE, CALC and DONE.
  - `ready` = IDLE or DONE.
  - `busy` = CALC.
  - `done` = DONE.
- Accept (`start`&`ready`&!`kill`) does the following:
  - latch funct3 and signs;
  - latch the magnitudes of signed operands;
  - clear the 2·XLEN accumulator;
  - load counter = XLEN−1;
  - go to CALC.
- Special-case accept goes directly to DONE, skipping CALC:
  - Divide by zero (`op_b`=0): quotient = all ones; remainder = `op_a`.
  - Signed overflow (DIV/REM, `op_a`=1<<(XLEN−1), `op_b`=all ones): quotient = `op_a`; remainder = 0.
- CALC performs one radix-2 step per cycle:
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - Counter decrements each step; at 0 the unit goes to DONE.
- The transition into DONE registers `result`:
  - select low or high half (multiply) or quotient or remainder (divide);
  - negate if the sign rule applies.
- Sign rules:
  - Product is negative iff the signed operand signs differ.
  - Quotient is negative iff the signs differ.
  - Remainder takes the sign of the dividend.
- DONE lasts one cycle, then the unit goes to IDLE. An accept in DONE goes directly to CALC (or DONE for special cases).
- `kill`:
  - In CALC: next state IDLE, no `done`, `result` unchanged.
  - In IDLE or DONE: blocks the accept; `done` in DONE still pulses.
- `start` while in CALC is ignored; the operands are not sampled.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0, counter=0, accumulator=0. Reset takes effect immediately, including mid-operation.
- Normal latency: accept on edge k, then `done` is high in the cycle after edge k+XLEN+1, i.e. XLEN+1 cycles. Throughput is one op per XLEN+1 cycles back-to-back.
- Special-case latency: `done` is high in the cycle after edge k+1, i.e. 1 cycle.
- `busy` is high for exactly XLEN cycles per normal op.
- `result` is registered. It is stable from the `done` cycle until the next `done`.
- `kill` in CALC: `ready`=1 in the next cycle.

## Structure
- `muldiv_pkg` contains:
  - funct3 localparams (`F3_MUL` … `F3_REMU`);
  - the state enum;
  - the helper functions `is_div(funct3)` and `is_signed_a/b(funct3)`.
- `muldiv_neg` is the one sub-module: a parametrised conditional two's-complement negate (XLEN wide).
  - Instantiated for operand magnitude on `op_a` and `op_b`.
  - Instantiated for result sign fix.
- The datapath uses one shared 2·XLEN accumulator for both the multiply and divide paths.

## Test plan
All scenarios use XLEN=32.
- MUL, `op_a`=7, `op_b`=0xFFFFFFFD → `result`=0xFFFFFFEB; `done` 33 cycles after accept; `busy` high for 32 cycles.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases, each with `done` 1 cycle after accept and `busy` never high:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Control:
  - `kill` in CALC cycle 10 → no `done`; `ready`=1 next cycle; `result` keeps its old value.
  - `start` with new operands during CALC → ignored; the first op's result is correct.
  - `rst_n` low mid-CALC → all outputs 0 and `ready`=1 asynchronously.
- Back-to-back: `start` held high in the DONE cycle of op 1 → op 2 accepted; its `done` comes 33 cycles later; op 1's `result` holds until then.
